// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Exports the FSM state enum, default width, latency and INT_MIN.
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = 34;

    localparam logic [DIV_WIDTH-1:0] INT_MIN =
        {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Ports: r, q, b -> r_next, q_next (shift, trial subtract, select).
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] diff;
    logic             co;
    logic             fit;

    assign rs = {r[WIDTH-2:0], q[WIDTH-1]};

    // rs + ~b + 1: carry-out set means no borrow
    full_adder #(.WIDTH(WIDTH)) u_sub (
        .a   (rs),
        .b   (~b),
        .cin (1'b1),
        .sum (diff),
        .cout(co)
    );

    // a bit shifted out of r means rs already exceeds b
    assign fit    = co | r[WIDTH-1];
    assign r_next = fit ? diff : rs;
    assign q_next = {q[WIDTH-2:0], fit};

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit adder with carry in/out, shared by subtractor and negators.
// Ports: a, b, cin -> sum, cout.
module full_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b}
                       + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring, one bit per cycle.
// Ports: clock, reset_n, ctrl_div, data_operandA/B in;
//        data_result, data_remainder, data_exception,
//        data_resultRDY (1-cycle pulse), busy out.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MINV =
        {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic             qsign;
    logic             rsign;
    logic             ovf;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] nx_in;
    logic [WIDTH-1:0] ny_in;
    logic [WIDTH-1:0] nx;
    logic [WIDTH-1:0] ny;
    logic             negx_unused;
    logic             negy_unused;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r     (r),
        .q     (q),
        .b     (mag_b),
        .r_next(step_r),
        .q_next(step_q)
    );

    // Negators are shared: operand magnitudes on
    // accept, result sign fix-up in SIGN.
    assign nx_in = (state == SIGN) ? q : data_operandA;
    assign ny_in = (state == SIGN) ? r : data_operandB;

    full_adder #(.WIDTH(WIDTH)) u_negx (
        .a   (~nx_in),
        .b   ({WIDTH{1'b0}}),
        .cin (1'b1),
        .sum (nx),
        .cout(negx_unused)
    );

    full_adder #(.WIDTH(WIDTH)) u_negy (
        .a   (~ny_in),
        .b   ({WIDTH{1'b0}}),
        .cin (1'b1),
        .sum (ny),
        .cout(negy_unused)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            mag_b          <= '0;
            r              <= '0;
            q              <= '0;
            qsign          <= 1'b0;
            rsign          <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (ctrl_div) begin
                        if (data_operandB == '0) begin
                            state          <= DONE;
                            data_result    <= '0;
                            data_remainder <= '0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            count <= '0;
                            r     <= '0;
                            q     <= data_operandA[WIDTH-1]
                                   ? nx : data_operandA;
                            mag_b <= data_operandB[WIDTH-1]
                                   ? ny : data_operandB;
                            qsign <= data_operandA[WIDTH-1]
                                   ^ data_operandB[WIDTH-1];
                            rsign <= data_operandA[WIDTH-1];
                            ovf   <= (data_operandA == MINV)
                                   && (&data_operandB);
                        end
                    end
                end
                RUN: begin
                    r     <= step_r;
                    q     <= step_q;
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= SIGN;
                end
                SIGN: begin
                    // remainder follows dividend sign
                    data_result    <= qsign ? nx : q;
                    data_remainder <= rsign ? ny : r;
                    data_exception <= ovf;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state          <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
